// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - RV32M multiply/divide unit for the EX stage (shift-add multiply, restoring divide)
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply; divide stays iterative.
module ex_muldiv #(
  parameter int unsigned WIDTH  = 32,
  parameter logic [6:0]  OP_REG = 7'b0110011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  input  logic [6:0]       EX_op,
  input  logic [6:0]       EX_funct7,
  input  logic [2:0]       EX_funct3,
  input  logic [WIDTH-1:0] EX_rs1_data,
  input  logic [WIDTH-1:0] EX_rs2_data,
  output logic             md_stall,
  output logic             md_busy,
  output logic             md_valid,
  output logic [WIDTH-1:0] md_result
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [1:0]         f3_q, f3_d;
  logic               neg_q, neg_d;
  logic               nrem_q, nrem_d;
  logic [WIDTH-1:0]   res_q, res_d;

  logic             start, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf, last;
  logic [WIDTH-1:0] a_abs, b_abs;

  // Operands are converted to magnitudes at start; signs are reapplied on the final edge.
  assign start    = (state_q == S_IDLE) && (EX_op == OP_REG) && (EX_funct7 == 7'b0000001)
                    && !flush && !rst;
  assign a_sgn    = EX_funct3[2] ? !EX_funct3[0] : (EX_funct3[1:0] != 2'b11);
  assign b_sgn    = EX_funct3[2] ? !EX_funct3[0] : !EX_funct3[1];
  assign a_neg    = a_sgn && EX_rs1_data[WIDTH-1];
  assign b_neg    = b_sgn && EX_rs2_data[WIDTH-1];
  assign a_abs    = a_neg ? -EX_rs1_data : EX_rs1_data;
  assign b_abs    = b_neg ? -EX_rs2_data : EX_rs2_data;
  assign div_zero = (EX_rs2_data == '0);
  assign div_ovf  = !EX_funct3[0] && (EX_rs1_data == {1'b1, {(WIDTH-1){1'b0}}})
                    && (EX_rs2_data == '1);
  assign last     = (cnt_q == CW'(WIDTH-1));

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt, mul_prod;
  logic [WIDTH:0]     div_r;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub, div_q, div_rem;
  logic [2*WIDTH-1:0] div_nxt;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_nxt  = {mul_sum, acc_q[WIDTH-1:1]};
  assign mul_prod = neg_q ? -mul_nxt : mul_nxt;

  assign div_r    = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge   = (div_r >= {1'b0, opb_q});
  assign div_sub  = div_r[WIDTH-1:0] - opb_q;
  assign div_nxt  = div_ge ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                           : {div_r[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  assign div_q    = neg_q  ? -div_nxt[WIDTH-1:0] : div_nxt[WIDTH-1:0];
  assign div_rem  = nrem_q ? -div_nxt[2*WIDTH-1:WIDTH] : div_nxt[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MUL_EN
  logic signed [WIDTH:0]     fast_a, fast_b;
  logic        [2*WIDTH-1:0] fast_prod;
  assign fast_a    = {a_sgn && EX_rs1_data[WIDTH-1], EX_rs1_data};
  assign fast_b    = {b_sgn && EX_rs2_data[WIDTH-1], EX_rs2_data};
  assign fast_prod = (2*WIDTH)'(fast_a * fast_b);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    f3_d    = f3_q;
    neg_d   = neg_q;
    nrem_d  = nrem_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d  = EX_funct3[1:0];
          cnt_d = '0;
          neg_d = a_neg ^ b_neg;
          if (EX_funct3[2]) begin
            opb_d  = b_abs;
            acc_d  = {{WIDTH{1'b0}}, a_abs};
            nrem_d = a_neg;
            if (div_zero) begin
              state_d = S_DONE;
              res_d   = EX_funct3[1] ? EX_rs1_data : '1;
            end else if (div_ovf) begin
              state_d = S_DONE;
              res_d   = EX_funct3[1] ? '0 : EX_rs1_data;
            end else begin
              state_d = S_DIV;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            state_d = S_DONE;
            res_d   = (EX_funct3[1:0] == 2'b00) ? fast_prod[WIDTH-1:0]
                                                : fast_prod[2*WIDTH-1:WIDTH];
`else
            opb_d   = a_abs;
            acc_d   = {{WIDTH{1'b0}}, b_abs};
            state_d = S_MUL;
`endif
          end
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = mul_nxt;
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            state_d = S_DONE;
            res_d   = (f3_q == 2'b00) ? mul_prod[WIDTH-1:0] : mul_prod[2*WIDTH-1:WIDTH];
          end
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = div_nxt;
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            state_d = S_DONE;
            res_d   = f3_q[1] ? div_rem : div_q;
          end
        end
      end
      default: begin
        if (flush || !hold) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      nrem_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      nrem_q  <= nrem_d;
      res_q   <= res_d;
    end
  end

  assign md_busy   = (state_q == S_MUL) || (state_q == S_DIV);
  assign md_stall  = start || (md_busy && !flush);
  assign md_valid  = (state_q == S_DONE);
  assign md_result = res_q;

endmodule
